// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// a constant-width helper for the bit counter.
package sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor: d = a - b - bin, bout set when the column borrows.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub4.sv
// Bit-serial subtractor diff = a - b, LSB first, behind valid/ready ports.
// Optional signed-overflow output ovf is built when SERIAL_SUB_OVF_EN is defined.
module serial_sub4
  import sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = clog2(WIDTH);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // in_ready and out_valid are registered, and no drain and accept share a cycle.

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             cell_d;
  logic             cell_bout;
  logic [WIDTH-1:0] res_full;
  logic             accept;
  logic             finish;

  full_sub_cell u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // The newest difference bit enters at the top; the final shift completes the word.
  assign res_full = {cell_d, res_q};
  assign accept   = (state_q == S_IDLE) && in_ready_q && in_valid;
  assign finish   = (state_q == S_SHIFT) && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_d       = res_q;
    diff_d      = diff_q;
    br_d        = br_q;
    borrow_d    = borrow_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_sh_d     = a;
          b_sh_d     = b;
          br_d       = 1'b0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = S_SHIFT;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      S_SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = cell_bout;
        res_d  = res_full[WIDTH-1:1];
        cnt_d  = cnt_q + 1'b1;
        if (finish) begin
          diff_d      = res_full;
          borrow_d    = cell_bout;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_q       <= '0;
      diff_q      <= '0;
      br_q        <= 1'b0;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_q       <= res_d;
      diff_q      <= diff_d;
      br_q        <= br_d;
      borrow_q    <= borrow_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;

`ifdef SERIAL_SUB_OVF_EN
  // Operand MSBs are lost from the shift registers, so keep a copy for overflow.
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;

  always_comb begin
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
    end
    if (finish) begin
      ovf_d = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub4.sv
// Directed bench for serial_sub4 (WIDTH=4): table of operand/result vectors
// plus hand-written backpressure, ignored-input and mid-operation reset sequences.
module tb_serial_sub4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a, b, diff;
    logic         borrow, ovf;
    int           hold;
  } vec_t;
  vec_t vecs[8];

  serial_sub4 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ready(input string name);
    int t;
    t = 0;
    while (in_ready !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  // Called at a falling edge; leaves the bench at a falling edge.
  task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic eb, input logic eo, input int hold);
    int lat;
    wait_ready(name);
    in_valid = 1'b1;
    a = av;
    b = bv;
    exp_q.push_back(ed);
    step();
    in_valid = 1'b0;
    a = W'($urandom_range(0, 15));
    b = W'($urandom_range(0, 15));
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      step();
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(W));
    for (int i = 0; i < hold; i++) begin
      check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({name, "_hold_diff"}, 32'(diff), 32'(ed));
      step();
    end
    check({name, "_diff"}, 32'(diff), 32'(exp_q.pop_front()));
    check({name, "_borrow"}, 32'(borrow_out), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    check({name, "_ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("note: undefined ovf expectation for %s", name);
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({name, "_drained"}, 32'(out_valid), 32'd0);
    check({name, "_ready_again"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 0};
    vecs[1] = '{4'h3, 4'h2, 4'h1, 1'b0, 1'b0, 0};
    vecs[2] = '{4'h7, 4'hA, 4'hD, 1'b1, 1'b1, 0};
    vecs[3] = '{4'hA, 4'h7, 4'h3, 1'b0, 1'b1, 0};
    vecs[4] = '{4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 3};
    vecs[5] = '{4'h0, 4'h1, 4'hF, 1'b1, 1'b0, 0};
    vecs[6] = '{4'h8, 4'h1, 4'h7, 1'b0, 1'b1, 0};
    vecs[7] = '{4'h5, 4'h5, 4'h0, 1'b0, 1'b0, 1};

    // Reset state.
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    step();
    check("rel_in_ready_high", 32'(in_ready), 32'd1);

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].diff,
             vecs[i].borrow, vecs[i].ovf, vecs[i].hold);
    end

    // in_valid held high through SHIFT and DONE must not start a second operation.
    wait_ready("ign");
    in_valid = 1'b1;
    a = 4'hF;
    b = 4'hF;
    step();
    a = 4'h5;
    b = 4'h1;
    for (int i = 0; i < W; i++) begin
      check("ign_busy_shift", 32'(in_ready), 32'd0);
      step();
    end
    check("ign_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("ign_busy_done", 32'(in_ready), 32'd0);
      check("ign_hold_valid", 32'(out_valid), 32'd1);
      check("ign_hold_diff", 32'(diff), 32'h0);
      step();
    end
    in_valid = 1'b0;
    check("ign_borrow", 32'(borrow_out), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("ign_drained", 32'(out_valid), 32'd0);
    repeat (8) step();
    check("ign_no_extra", 32'(out_valid), 32'd0);

    // Reset in the second SHIFT cycle aborts the operation.
    run_op("pre", 4'h3, 4'h2, 4'h1, 1'b0, 1'b0, 0);
    wait_ready("abort");
    in_valid = 1'b1;
    a = 4'h9;
    b = 4'h6;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_borrow", 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("abort_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    step();
    check("abort_no_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    check("abort_rel_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    step();
    check("abort_rel_ready_high", 32'(in_ready), 32'd1);
    run_op("post", 4'h6, 4'h9, 4'hD, 1'b1, 1'b1, 0);
    repeat (6) step();
    check("post_no_extra", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
